// File: rtl/wb_stream_arbiter.sv
// wb_stream_arbiter
//   Two-master to one-slave Wishbone arbiter with a stall watchdog.
//   An idle bus is arbitrated in one cycle, using a last-served pointer so
//   that neither master can starve the other. The winner keeps the bus for
//   its whole cycle, whatever the burst length. A watchdog aborts a cycle
//   whose strobe has gone unanswered for TIMEOUT cycles.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   m0_*_i / m1_*_i              master request side (adr, dat, sel, we,
//                                cyc, stb, cti, bte)
//   m0_*_o / m1_*_o              master response side (dat, ack, err, rty)
//   s_*_o                        slave request side, muxed from the owner
//   s_dat_i, s_ack_i/err_i/rty_i slave responses
//   grant_o                      one-hot owner (00 = idle)
//   timeout_o                    one-cycle pulse when the watchdog aborts
module wb_stream_arbiter #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  // master 0
  input  logic [WB_AW-1:0]     m0_adr_i,
  input  logic [WB_DW-1:0]     m0_dat_i,
  input  logic [WB_DW/8-1:0]   m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic [2:0]           m0_cti_i,
  input  logic [1:0]           m0_bte_i,
  output logic [WB_DW-1:0]     m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  output logic                 m0_rty_o,
  // master 1
  input  logic [WB_AW-1:0]     m1_adr_i,
  input  logic [WB_DW-1:0]     m1_dat_i,
  input  logic [WB_DW/8-1:0]   m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic [2:0]           m1_cti_i,
  input  logic [1:0]           m1_bte_i,
  output logic [WB_DW-1:0]     m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 m1_rty_o,
  // slave
  output logic [WB_AW-1:0]     s_adr_o,
  output logic [WB_DW-1:0]     s_dat_o,
  output logic [WB_DW/8-1:0]   s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic [2:0]           s_cti_o,
  output logic [1:0]           s_bte_o,
  input  logic [WB_DW-1:0]     s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,
  // status
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0] state, state_nxt;
  logic       last_gnt, last_gnt_nxt;  // 0: m0 served last, 1: m1 served last
  logic       arb_en;                  // low for the first edge after reset release
  logic       cyc_req, stb_req;        // owner's cyc/stb before abort gating
  logic       resp_any;
  logic       abort;

  assign grant_o  = state;
  assign resp_any = s_ack_i | s_err_i | s_rty_i;

  // Request path: owner's inputs straight through, everything quiet when idle
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    cyc_req = 1'b0;
    stb_req = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
        cyc_req = m0_cyc_i;
        stb_req = m0_stb_i;
      end
      GNT1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
        cyc_req = m1_cyc_i;
        stb_req = m1_stb_i;
      end
      default: ;
    endcase
  end

  // An abort drops the bus in the same cycle it is detected
  assign s_cyc_o = cyc_req & ~abort;
  assign s_stb_o = stb_req & ~abort;

  // Response path: data broadcast, handshakes only to the owner. In the
  // abort cycle the slave is ignored and the owner sees err alone.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state == GNT0) & s_ack_i & ~abort;
  assign m0_rty_o = (state == GNT0) & s_rty_i & ~abort;
  assign m0_err_o = (state == GNT0) & (abort | s_err_i);
  assign m1_ack_o = (state == GNT1) & s_ack_i & ~abort;
  assign m1_rty_o = (state == GNT1) & s_rty_i & ~abort;
  assign m1_err_o = (state == GNT1) & (abort | s_err_i);

  // Stall watchdog
  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] wd_cnt;
      logic          stalled;

      assign stalled = stb_req & ~resp_any;
      assign abort   = stalled && (wd_cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
          wd_cnt <= '0;
        else if (!stalled || abort)
          wd_cnt <= '0;
        else if (wd_cnt != CW'(TIMEOUT))
          wd_cnt <= wd_cnt + CW'(1);
      end
    end else begin : g_no_wdog
      assign abort = 1'b0;
    end
  endgenerate

  assign timeout_o = abort;

  // Arbitration and cycle tracking
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (arb_en) begin
          if (m0_cyc_i && m1_cyc_i)
            state_nxt = last_gnt ? GNT0 : GNT1;
          else if (m0_cyc_i)
            state_nxt = GNT0;
          else if (m1_cyc_i)
            state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (abort || !m0_cyc_i) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (abort || !m1_cyc_i) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      arb_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      arb_en   <= 1'b1;
    end
  end

endmodule
